// File: rtl/stream_encoder.sv
// stream_encoder: table-driven variable-length encoder that packs prefix codes MSB-first into
// WIDTH_OUT-bit words behind a small output FIFO. Define STREAM_ENCODER_BIT_COUNT_EN for bit_count.
module stream_encoder #(
  parameter int unsigned WIDTH_IN             = 8,
  parameter int unsigned WIDTH_OUT            = 8,
  parameter int unsigned MAX_CODE_LENGTH      = 8,
  parameter int unsigned LOG2_MAX_CODE_LENGTH = $clog2(MAX_CODE_LENGTH),
  parameter int unsigned OUT_DEPTH            = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            push,
  input  logic [WIDTH_IN-1:0]             d,
  output logic                            full,
  output logic                            half_full,
  input  logic                            flush,
  output logic [WIDTH_OUT-1:0]            q,
  output logic                            ready,
  input  logic                            pop,
  input  logic                            table_push,
  input  logic [WIDTH_IN-1:0]             table_addr,
  input  logic [MAX_CODE_LENGTH-1:0]      table_code,
  input  logic [LOG2_MAX_CODE_LENGTH:0]   table_code_width
`ifdef STREAM_ENCODER_BIT_COUNT_EN
  ,
  output logic [31:0]                     bit_count
`endif
);

  localparam int unsigned CW    = LOG2_MAX_CODE_LENGTH + 1;
  localparam int unsigned ML1   = MAX_CODE_LENGTH + 1;
  localparam int unsigned DEPTH = 2 ** WIDTH_IN;
  localparam int unsigned ACC_W = WIDTH_OUT + MAX_CODE_LENGTH;
  localparam int unsigned SUM_W = $clog2(ACC_W + MAX_CODE_LENGTH + 1);
  localparam int unsigned PTR_W = $clog2(OUT_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [MAX_CODE_LENGTH-1:0] tbl_code_mem [DEPTH];
  logic [CW-1:0]              tbl_width_mem [DEPTH];
  logic                       tw_push_q;
  logic [WIDTH_IN-1:0]        tw_addr_q;
  logic [MAX_CODE_LENGTH-1:0] tw_code_q;
  logic [CW-1:0]              tw_width_q;

  logic                       s1_valid_q, s1_valid_d;
  logic [MAX_CODE_LENGTH-1:0] s1_code_q, s1_code_d;
  logic [CW-1:0]              s1_width_q, s1_width_d;

  logic [ACC_W-1:0]           acc_q, acc_d, acc_base;
  logic [SUM_W-1:0]           acc_cnt_q, acc_cnt_d, cnt_after, shamt;
  logic                       flush_pend_q, flush_pend_d;

  logic [WIDTH_OUT-1:0]       fifo_mem [OUT_DEPTH];
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]           fifo_cnt_q, fifo_cnt_d;

  logic                       pop_c, fifo_space, drain_full, drain_tail, drain, append, accept;
  logic [ML1-1:0]             one_hot;
  logic [MAX_CODE_LENGTH-1:0] code_mask;

  // Table write path: inputs registered one cycle, widths clamped to the legal maximum.
  always_ff @(posedge clk) begin
    tw_push_q  <= table_push;
    tw_addr_q  <= table_addr;
    tw_code_q  <= table_code;
    tw_width_q <= (table_code_width > CW'(MAX_CODE_LENGTH)) ? CW'(MAX_CODE_LENGTH)
                                                             : table_code_width;
    if (tw_push_q) begin
      tbl_code_mem[tw_addr_q]  <= tw_code_q;
      tbl_width_mem[tw_addr_q] <= tw_width_q;
    end
  end

  // Drain, append, flush and FIFO bookkeeping for the next edge.
  always_comb begin
    ready      = (fifo_cnt_q != '0);
    half_full  = (fifo_cnt_q >= CNT_W'(OUT_DEPTH / 2));
    q          = ready ? fifo_mem[rd_ptr_q] : '0;
    pop_c      = pop && ready;
    fifo_space = (fifo_cnt_q != CNT_W'(OUT_DEPTH)) || pop_c;
    drain_full = (acc_cnt_q >= SUM_W'(WIDTH_OUT)) && fifo_space;
    drain_tail = flush_pend_q && !s1_valid_q && (acc_cnt_q != '0) &&
                 (acc_cnt_q < SUM_W'(WIDTH_OUT)) && fifo_space;
    drain      = drain_full || drain_tail;
    cnt_after  = drain_full ? (acc_cnt_q - SUM_W'(WIDTH_OUT)) : (drain_tail ? '0 : acc_cnt_q);
    acc_base   = drain ? (acc_q << WIDTH_OUT) : acc_q;
    append     = s1_valid_q && ((cnt_after + SUM_W'(s1_width_q)) <= SUM_W'(ACC_W));
    full       = (s1_valid_q && !append) || flush_pend_q;
    accept     = push && !full;

    one_hot    = ML1'(1) << s1_width_q;
    code_mask  = MAX_CODE_LENGTH'(one_hot - ML1'(1));
    shamt      = SUM_W'(ACC_W) - cnt_after - SUM_W'(s1_width_q);
    acc_d      = acc_base;
    acc_cnt_d  = cnt_after;
    if (append) begin
      acc_d     = acc_base | (ACC_W'(s1_code_q & code_mask) << shamt);
      acc_cnt_d = cnt_after + SUM_W'(s1_width_q);
    end

    s1_valid_d = s1_valid_q && !append;
    s1_code_d  = s1_code_q;
    s1_width_d = s1_width_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_code_d  = tbl_code_mem[d];
      s1_width_d = tbl_width_mem[d];
    end

    flush_pend_d = flush_pend_q;
    if (flush_pend_q && !s1_valid_q && (acc_cnt_q == '0)) flush_pend_d = 1'b0;
    if (flush) flush_pend_d = 1'b1;

    wr_ptr_d   = drain ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop_c ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q + CNT_W'(drain) - CNT_W'(pop_c);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid_q   <= 1'b0;
      acc_q        <= '0;
      acc_cnt_q    <= '0;
      flush_pend_q <= 1'b0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      fifo_cnt_q   <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      acc_q        <= acc_d;
      acc_cnt_q    <= acc_cnt_d;
      flush_pend_q <= flush_pend_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      fifo_cnt_q   <= fifo_cnt_d;
    end
  end

  // Payload registers carry no reset; validity is tracked by s1_valid_q and the FIFO count.
  always_ff @(posedge clk) begin
    s1_code_q  <= s1_code_d;
    s1_width_q <= s1_width_d;
    if (rst && drain) fifo_mem[wr_ptr_q] <= acc_q[ACC_W-1 -: WIDTH_OUT];
  end

`ifdef STREAM_ENCODER_BIT_COUNT_EN
  logic [31:0] bit_cnt_q, bit_cnt_d;

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    if (append) bit_cnt_d = bit_cnt_q + 32'(s1_width_q);
  end

  always_ff @(posedge clk) begin
    if (!rst) bit_cnt_q <= '0;
    else      bit_cnt_q <= bit_cnt_d;
  end

  assign bit_count = bit_cnt_q;
`endif

endmodule

// File: tb/tb_stream_encoder.sv
// tb_stream_encoder: directed scenarios plus randomized traffic checked against a bit-queue
// model of the encoder (code bits in, zero-padded words out, in order).
module tb_stream_encoder;

  localparam int unsigned WI = 8;
  localparam int unsigned WO = 8;
  localparam int unsigned ML = 8;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          push;
  logic [WI-1:0] d;
  logic          full;
  logic          half_full;
  logic          flush;
  logic [WO-1:0] q;
  logic          ready;
  logic          pop;
  logic          table_push;
  logic [WI-1:0] table_addr;
  logic [ML-1:0] table_code;
  logic [CW-1:0] table_code_width;
`ifdef STREAM_ENCODER_BIT_COUNT_EN
  logic [31:0]   bit_count;
`endif

  stream_encoder dut (
    .clk              (clk),
    .rst              (rst),
    .push             (push),
    .d                (d),
    .full             (full),
    .half_full        (half_full),
    .flush            (flush),
    .q                (q),
    .ready            (ready),
    .pop              (pop),
    .table_push       (table_push),
    .table_addr       (table_addr),
    .table_code       (table_code),
    .table_code_width (table_code_width)
`ifdef STREAM_ENCODER_BIT_COUNT_EN
    ,
    .bit_count        (bit_count)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;
  bit          chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: table as seen by pushes, a queue of emitted code bits, and a queue of finished words.
  logic [ML-1:0] m_code [256];
  logic [CW-1:0] m_w [256];
  bit            m_bits[$];
  logic [WO-1:0] m_words[$];
  logic [31:0]   m_total = 32'd0;

  initial begin : model
    bit            tw_v;
    logic [WI-1:0] tw_a;
    logic [ML-1:0] tw_c;
    logic [CW-1:0] tw_w;
    int            w;
    logic [WO-1:0] wd;
    tw_v = 1'b0;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        if (!ready)                  chk("q_idle", 32'(q), 32'd0);
        else if (m_words.size() == 0) chk("ready_without_word", 32'(ready), 32'd0);
        else                          chk("q_head", 32'(q), 32'(m_words[0]));
      end
      if (!rst) begin
        m_bits.delete();
        m_words.delete();
        m_total = 32'd0;
      end else begin
        if (pop && ready && m_words.size() != 0) void'(m_words.pop_front());
        if (push && !full) begin
          w = (int'(m_w[d]) > int'(ML)) ? int'(ML) : int'(m_w[d]);
          for (int i = w - 1; i >= 0; i--) m_bits.push_back(m_code[d][i]);
          m_total += 32'(w);
        end
        if (flush) while (m_bits.size() % WO != 0) m_bits.push_back(1'b0);
        while (m_bits.size() >= WO) begin
          wd = '0;
          for (int i = 0; i < int'(WO); i++) wd[WO-1-i] = m_bits.pop_front();
          m_words.push_back(wd);
        end
      end
      if (tw_v) begin
        m_code[tw_a] = tw_c;
        m_w[tw_a]    = tw_w;
      end
      tw_v = table_push;
      tw_a = table_addr;
      tw_c = table_code;
      tw_w = table_code_width;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    push = 1'b0; pop = 1'b0; flush = 1'b0; table_push = 1'b0;
  endtask

  task automatic twrite(input logic [WI-1:0] a, input logic [ML-1:0] c, input logic [CW-1:0] w);
    table_push = 1'b1; table_addr = a; table_code = c; table_code_width = w;
    cyc();
    table_push = 1'b0;
  endtask

  task automatic do_reset(input int n);
    idle();
    rst = 1'b0;
    repeat (n) cyc();
    rst = 1'b1;
  endtask

  task automatic wait_not_full(input string name);
    int k = 0;
    while (full && k < 50) begin cyc(); k++; end
    chk(name, 32'(full), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_n;
    int got;
    int k;
    rst = 1'b0; d = '0; table_addr = '0; table_code = '0; table_code_width = '0;
    idle();
    repeat (3) cyc();
    rst = 1'b1;
    chk_en = 1'b1;

    for (int a = 0; a < 256; a++) twrite(WI'(a), ML'(a), CW'(8));
    twrite(8'h41, 8'h05, 4'd3);
    twrite(8'h42, 8'h06, 4'd5);
    twrite(8'h43, 8'h02, 4'd3);
    twrite(8'h44, 8'hFF, 4'd0);
    twrite(8'h45, 8'h0B, 4'd4);
    repeat (3) cyc();

    // Reset with traffic in flight; table must survive.
    for (int i = 0; i < 4; i++) begin push = 1'b1; d = WI'(i); cyc(); end
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      push = (i == 0); pop = (i != 0); d = 8'h45;
      cyc();
      chk("reset_ready", 32'(ready), 32'd0);
      chk("reset_full", 32'(full), 32'd0);
      chk("reset_half_full", 32'(half_full), 32'd0);
      chk("reset_q", 32'(q), 32'd0);
    end
    rst = 1'b1; idle();
    push = 1'b1; d = 8'h45; cyc();
    push = 1'b0; flush = 1'b1; cyc(); flush = 1'b0;
    wait_not_full("reset_flush_done");
    chk("reset_table_kept_ready", 32'(ready), 32'd1);
    chk("reset_table_kept_q", 32'(q), 32'hB0);
    pop = 1'b1; cyc(); pop = 1'b0;

    // Packing 101 + 00110 -> 0xA6.
    do_reset(1);
    push = 1'b1; d = 8'h41; cyc();
    d = 8'h42; cyc();
    push = 1'b0; cyc();
    chk("pack_not_yet_ready", 32'(ready), 32'd0);
    cyc();
    chk("pack_ready", 32'(ready), 32'd1);
    chk("pack_q", 32'(q), 32'hA6);
    pop = 1'b1; cyc(); pop = 1'b0;
    chk("pack_popped", 32'(ready), 32'd0);
    flush = 1'b1; cyc(); flush = 1'b0;
    wait_not_full("pack_flush_done");
    chk("pack_flush_empty", 32'(ready), 32'd0);
`ifdef STREAM_ENCODER_BIT_COUNT_EN
    chk("pack_bit_count", bit_count, 32'd8);
`endif

    // Flush of a 3-bit tail.
    do_reset(1);
    push = 1'b1; d = 8'h41; cyc();
    push = 1'b0; flush = 1'b1; cyc(); flush = 1'b0;
    chk("flush_full_pending", 32'(full), 32'd1);
    wait_not_full("flush_done");
    chk("flush_ready", 32'(ready), 32'd1);
    chk("flush_q", 32'(q), 32'hA0);
    pop = 1'b1; cyc(); pop = 1'b0;
    flush = 1'b1; cyc(); flush = 1'b0;
    repeat (3) cyc();
    chk("flush_second_empty", 32'(ready), 32'd0);

    // Table write hazard and zero-width code.
    do_reset(1);
    table_push = 1'b1; table_addr = 8'h43; table_code = 8'h01; table_code_width = 4'd1;
    cyc();
    table_push = 1'b0;
    push = 1'b1; d = 8'h43;
    chk("hazard_accept_old", 32'(full), 32'd0);
    cyc();
    chk("hazard_accept_new", 32'(full), 32'd0);
    cyc();
    d = 8'h44;
    chk("hazard_accept_w0", 32'(full), 32'd0);
    cyc();
    push = 1'b0; flush = 1'b1; cyc(); flush = 1'b0;
    wait_not_full("hazard_flush_done");
    chk("hazard_ready", 32'(ready), 32'd1);
    chk("hazard_q", 32'(q), 32'h50);
    pop = 1'b1; cyc(); pop = 1'b0;
    repeat (2) cyc();
    chk("hazard_w0_nothing", 32'(ready), 32'd0);

    // Backpressure with 8-bit identity codes and no pop.
    do_reset(1);
    acc_n = 0;
    for (int i = 0; i < 10; i++) begin
      push = 1'b1; d = WI'(i);
      if (!full) acc_n++;
      cyc();
    end
    push = 1'b0;
    chk("bp_accepted", 32'(acc_n), 32'd7);
    chk("bp_full", 32'(full), 32'd1);
    chk("bp_half_full", 32'(half_full), 32'd1);
    chk("bp_ready", 32'(ready), 32'd1);
    pop = 1'b1; got = 0; k = 0;
    while (got < 7 && k < 40) begin
      if (ready) begin chk("bp_word", 32'(q), 32'(got)); got++; end
      cyc(); k++;
    end
    pop = 1'b0;
    chk("bp_word_count", 32'(got), 32'd7);
    repeat (2) cyc();
    chk("bp_no_extra", 32'(ready), 32'd0);

    // Randomized traffic with mid-stream table rewrites and flushes.
    for (int a = 0; a < 256; a++) twrite(WI'(a), ML'($urandom), CW'($urandom_range(0, 10)));
    do_reset(1);
    repeat (3) cyc();
    for (int c = 0; c < 3000; c++) begin
      push  = ($urandom_range(0, 9) < 7);
      d     = WI'($urandom);
      pop   = (c < 1500) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 7);
      flush = ($urandom_range(0, 63) == 0);
      table_push       = ($urandom_range(0, 49) == 0);
      table_addr       = WI'($urandom);
      table_code       = ML'($urandom);
      table_code_width = CW'($urandom_range(0, 10));
      cyc();
    end
    idle();
    flush = 1'b1; cyc(); flush = 1'b0;
    pop = 1'b1; k = 0;
    while ((m_words.size() != 0 || ready || full) && k < 300) begin cyc(); k++; end
    pop = 1'b0;
    cyc();
    chk("rand_drained_ready", 32'(ready), 32'd0);
    chk("rand_model_words_left", 32'(m_words.size()), 32'd0);
    chk("rand_model_bits_left", 32'(m_bits.size()), 32'd0);
`ifdef STREAM_ENCODER_BIT_COUNT_EN
    chk("rand_bit_count", bit_count, m_total);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
